crc_arbiter: RTL and testbench



---
 rtl/crc_arbiter_if.sv | 32 +++
 rtl/crc_arbiter.sv | 88 ++++++++
 tb/tb_crc_arbiter.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/crc_arbiter_if.sv
// Bus between the CRC arbiter, its two requesters and the external CRC engine.
// Requester handshake: reqN is a level held with a stable dataN until doneN
// pulses; the requester drops reqN on the edge where it sees doneN, and a
// reqN still high in IDLE is treated as a new request.
interface crc_arbiter_if #(
  parameter int DATA_W = 4,
  parameter int CRC_W  = 5
);
  logic              req0;
  logic [DATA_W-1:0] data0;
  logic              req1;
  logic [DATA_W-1:0] data1;
  logic              done0;
  logic              done1;
  logic [CRC_W-1:0]  crc_out;
  logic              busy;
  logic              owner;
  logic              eng_reset;
  logic [DATA_W-1:0] eng_data;
  logic [CRC_W-1:0]  eng_crc;
  logic [1:0]        dbg_state;

  modport slave (
    input  req0, data0, req1, data1, eng_crc,
    output done0, done1, crc_out, busy, owner, eng_reset, eng_data, dbg_state
  );

  modport master (
    output req0, data0, req1, data1, eng_crc,
    input  done0, done1, crc_out, busy, owner, eng_reset, eng_data, dbg_state
  );
endinterface

// File: rtl/crc_arbiter.sv
// Round-robin sharing of one external CRC engine between two requesters:
// reset-load, fixed calculation window, capture, then a done pulse to the owner.
module crc_arbiter #(
  parameter int DATA_W      = 4,
  parameter int CRC_W       = 5,
  parameter int RST_CYCLES  = 2,
  parameter int CALC_CYCLES = 8
) (
  input logic         clk,
  input logic         reset,
  crc_arbiter_if.slave bus
);
  localparam int MAX_CYC = (RST_CYCLES > CALC_CYCLES) ? RST_CYCLES : CALC_CYCLES;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, CALC, DONE} state_t;

  state_t           state;
  logic             last_owner;
  logic [CNT_W-1:0] cnt;
  logic             pick1;

  // On a tie the requester that was not served last wins.
  always_comb begin
    pick1 = 1'b0;
    if (bus.req1 && (!bus.req0 || !last_owner)) pick1 = 1'b1;
  end

  assign bus.dbg_state = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      last_owner    <= 1'b1;
      cnt           <= '0;
      bus.done0     <= 1'b0;
      bus.done1     <= 1'b0;
      bus.crc_out   <= '0;
      bus.busy      <= 1'b0;
      bus.owner     <= 1'b0;
      bus.eng_reset <= 1'b1;
      bus.eng_data  <= '0;
    end else begin
      bus.done0 <= 1'b0;
      bus.done1 <= 1'b0;
      case (state)
        IDLE: begin
          bus.eng_reset <= 1'b1;
          if (bus.req0 || bus.req1) begin
            bus.owner    <= pick1;
            last_owner   <= pick1;
            bus.eng_data <= pick1 ? bus.data1 : bus.data0;
            bus.busy     <= 1'b1;
            cnt          <= '0;
            state        <= LOAD;
          end
        end
        LOAD: begin
          if (cnt == CNT_W'(RST_CYCLES - 1)) begin
            cnt           <= '0;
            bus.eng_reset <= 1'b0;
            state         <= CALC;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        CALC: begin
          if (cnt == CNT_W'(CALC_CYCLES - 1)) begin
            cnt           <= '0;
            bus.crc_out   <= bus.eng_crc;
            bus.eng_reset <= 1'b1;
            bus.done0     <= ~bus.owner;
            bus.done1     <= bus.owner;
            state         <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          bus.eng_reset <= 1'b1;
          bus.busy      <= 1'b0;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_crc_arbiter.sv
// Bench for crc_arbiter: a registered CRC engine model on the eng_* side,
// requester driver tasks, and a done-side scoreboard.
module tb_crc_arbiter;
  localparam int DATA_W      = 4;
  localparam int CRC_W       = 5;
  localparam int RST_CYCLES  = 2;
  localparam int CALC_CYCLES = 8;
  localparam int LATENCY     = RST_CYCLES + CALC_CYCLES;

  logic clk;
  logic reset;
  int   cyc;
  int   total;
  int   bad;

  crc_arbiter_if #(.DATA_W(DATA_W), .CRC_W(CRC_W)) bus ();

  crc_arbiter #(
    .DATA_W(DATA_W), .CRC_W(CRC_W),
    .RST_CYCLES(RST_CYCLES), .CALC_CYCLES(CALC_CYCLES)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- engine model ----------------
  function automatic logic [CRC_W-1:0] crc_step(input logic [CRC_W-1:0] c,
                                                input logic [DATA_W-1:0] d);
    crc_step = {c[CRC_W-2:0], 1'b0} ^ (c[CRC_W-1] ? 5'h05 : 5'h00) ^ {1'b0, d};
  endfunction

  logic [CRC_W-1:0] eng_q;
  always_ff @(posedge clk) begin
    if (bus.eng_reset) eng_q <= '0;
    else               eng_q <= crc_step(eng_q, bus.eng_data);
  end
  assign bus.eng_crc = eng_q;

  // The engine samples eng_reset low for the first time one edge into the
  // window, so the captured value has seen CALC_CYCLES-1 steps.
  function automatic logic [CRC_W-1:0] exp_crc(input logic [DATA_W-1:0] d);
    logic [CRC_W-1:0] c;
    c = '0;
    for (int i = 0; i < CALC_CYCLES - 1; i++) c = crc_step(c, d);
    exp_crc = c;
  endfunction

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Entry: {owner, data, crc}
  logic [CRC_W+DATA_W:0] exp_q[$];
  int                    grant_q[$];

  task automatic push_exp(input logic o, input logic [DATA_W-1:0] d);
    exp_q.push_back({o, d, exp_crc(d)});
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic                  busy_prev;
  int                    grant_cyc;
  int                    low_cnt;
  logic [CRC_W+DATA_W:0] e;

  initial begin
    busy_prev = 1'b0;
    grant_cyc = 0;
    low_cnt   = 0;
  end

  always @(negedge clk) begin
    if (bus.busy && !busy_prev) begin
      grant_cyc = cyc;
      low_cnt   = 0;
      grant_q.push_back(cyc);
      if (exp_q.size() != 0) begin
        check("grant_owner", bus.owner, exp_q[0][CRC_W+DATA_W]);
        check("grant_data", bus.eng_data, exp_q[0][CRC_W+DATA_W-1:CRC_W]);
      end
    end
    if (!bus.eng_reset) low_cnt++;
    if (bus.done0 || bus.done1) begin
      check("done_excl", bus.done0 & bus.done1, 0);
      if (exp_q.size() == 0) begin
        check("spurious_done", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("done_sel", bus.done1, e[CRC_W+DATA_W]);
        check("owner", bus.owner, e[CRC_W+DATA_W]);
        check("crc_out", bus.crc_out, e[CRC_W-1:0]);
        check("eng_data_held", bus.eng_data, e[CRC_W+DATA_W-1:CRC_W]);
        check("latency", cyc - grant_cyc, LATENCY);
        check("calc_window", low_cnt, CALC_CYCLES);
        check("busy_in_done", bus.busy, 1);
      end
    end
    busy_prev = bus.busy;
  end

  // ---------------- driver tasks ----------------
  task automatic requester(input logic idx, input logic [DATA_W-1:0] d, input int delay);
    bit got;
    got = 0;
    repeat (delay) @(negedge clk);
    if (idx) begin bus.data1 = d; bus.req1 = 1'b1; end
    else     begin bus.data0 = d; bus.req0 = 1'b1; end
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (idx ? bus.done1 : bus.done0) begin got = 1; break; end
    end
    if (idx) bus.req1 = 1'b0;
    else     bus.req0 = 1'b0;
    if (!got) check(idx ? "timeout_req1" : "timeout_req0", 0, 1);
  endtask

  task automatic wait_busy(input string tag);
    bit got;
    got = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.busy) begin got = 1; break; end
    end
    if (!got) check(tag, 0, 1);
  endtask

  // ---------------- stimulus ----------------
  logic              ridx;
  logic [DATA_W-1:0] rdat;

  initial begin
    total     = 0;
    bad       = 0;
    cyc       = 0;
    reset     = 1'b1;
    bus.req0  = 1'b0;
    bus.req1  = 1'b0;
    bus.data0 = '0;
    bus.data1 = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_crc_out", bus.crc_out, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_eng_reset", bus.eng_reset, 1);
    check("rst_done0", bus.done0, 0);
    check("rst_done1", bus.done1, 0);
    check("rst_eng_data", bus.eng_data, 0);
    check("rst_owner", bus.owner, 0);

    // Tie after reset: requester 0 first, then 1; a repeated tie goes to 0 again.
    for (int t = 0; t < 2; t++) begin
      push_exp(1'b0, 4'b0010);
      push_exp(1'b1, 4'b1001);
      fork
        requester(1'b0, 4'b0010, 0);
        requester(1'b1, 4'b1001, 0);
      join
      @(negedge clk);
    end

    // Single request.
    push_exp(1'b0, 4'b0111);
    requester(1'b0, 4'b0111, 0);
    check("single_no_done1", bus.done1, 0);
    @(negedge clk);

    // Data change after grant is ignored.
    push_exp(1'b1, 4'b0000);
    fork
      requester(1'b1, 4'b0000, 0);
      begin
        wait_busy("timeout_grant_chg");
        @(negedge clk);
        bus.data1 = 4'b1111;
      end
    join
    @(negedge clk);

    // Random single requests.
    repeat (4) begin
      ridx = 1'($urandom_range(0, 1));
      rdat = DATA_W'($urandom_range(0, 15));
      push_exp(ridx, rdat);
      requester(ridx, rdat, $urandom_range(0, 2));
      @(negedge clk);
    end

    // Request while busy: req1 waits for the IDLE cycle after DONE.
    push_exp(1'b0, 4'b0011);
    push_exp(1'b1, 4'b0110);
    fork
      requester(1'b0, 4'b0011, 0);
      requester(1'b1, 4'b0110, 4);
    join
    check("busy_grant_spacing", grant_q[grant_q.size()-1] - grant_q[grant_q.size()-2],
          LATENCY + 2);
    @(negedge clk);

    // Mid-operation reset during CALC; req0 stays high and is served afterwards.
    push_exp(1'b0, 4'b1010);
    bus.data0 = 4'b1010;
    bus.req0  = 1'b1;
    wait_busy("timeout_grant_rst");
    repeat (RST_CYCLES + 3) @(negedge clk);
    check("pre_rst_in_calc", bus.eng_reset, 0);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_eng_reset", bus.eng_reset, 1);
    check("mid_rst_busy", bus.busy, 0);
    check("mid_rst_crc_out", bus.crc_out, 0);
    check("mid_rst_done0", bus.done0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    begin
      bit got;
      got = 0;
      for (int i = 0; i < 100; i++) begin
        @(negedge clk);
        if (bus.done0) begin got = 1; break; end
      end
      bus.req0 = 1'b0;
      if (!got) check("timeout_after_rst", 0, 1);
    end

    repeat (5) @(negedge clk);
    check("drain", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
